// File: rtl/lpd_ctrl_pkg.sv
// rtl/lpd_ctrl_pkg.sv - shared types and encodings for the multi-engine LPD controller
package lpd_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_LOAD_WAIT   = 2'd1,
        ST_ENG_WAIT    = 2'd2,
        ST_UNLOAD_WAIT = 2'd3
    } ctrl_state_t;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_LOAD   = 2'd1;
    localparam logic [1:0] ERR_ENG    = 2'd2;
    localparam logic [1:0] ERR_UNLOAD = 2'd3;

    localparam int BRAM_SEL_LMULM = 0;

    // Region arithmetic carries this many guard bits above the BRAM address width.
    localparam int ADDR_GUARD  = 4;
    localparam int ADDR_NB_DEF = 14;
    typedef logic [ADDR_NB_DEF+ADDR_GUARD-1:0] addr_calc_t;

    function automatic logic [1:0] err_code(input ctrl_state_t s);
        case (s)
            ST_LOAD_WAIT:   return ERR_LOAD;
            ST_ENG_WAIT:    return ERR_ENG;
            ST_UNLOAD_WAIT: return ERR_UNLOAD;
            default:        return ERR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/lpd_multi_engine_ctrl_watchdog.sv
// rtl/lpd_multi_engine_ctrl_watchdog.sv - per-wait-state timeout counter; TIMEOUT_CYC=0 disables it
module lpd_watchdog #(
    parameter int TIMEOUT_CYC = 2**20
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    if (TIMEOUT_CYC == 0) begin : g_off
        logic unused_in;
        assign unused_in = ^{clk, reset, clr, en};
        assign expire    = 1'b0;
    end else begin : g_on
        localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
        localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);
        logic [CW-1:0] count;

        // Saturate so a held wait never wraps back below the limit.
        always_ff @(posedge clk) begin
            if (reset || clr) begin
                count <= '0;
            end else if (en && count != LIMIT) begin
                count <= count + 1'b1;
            end
        end

        assign expire = en && (count == LIMIT);
    end

endmodule

// File: rtl/lpd_multi_engine_ctrl.sv
// rtl/lpd_multi_engine_ctrl.sv - sequences PN load, NUM_ENG engines and optional result unloads
module lpd_multi_engine_ctrl
    import lpd_ctrl_pkg::*;
#(
    parameter int ADDR_NB      = 14,
    parameter int NUM_ENG      = 2,
    parameter int LOAD_BASE    = 0,
    parameter int LOAD_WORDS   = 8192,
    parameter int UNLOAD_BASE  = 8192,
    parameter int UNLOAD_WORDS = 2048,
    parameter int TIMEOUT_CYC  = 2**20,
    localparam int SW = $clog2(NUM_ENG + 1),
    localparam int EW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               unload_en,
    input  logic               abort,
    output logic               ready,
    output logic               err,
    output logic [1:0]         err_state,
    input  logic               LM_ULM_ready,
    output logic               LM_ULM_start,
    output logic [ADDR_NB-1:0] LM_ULM_base_address,
    output logic [ADDR_NB-1:0] LM_ULM_upper_limit,
    output logic               LM_ULM_load_unload,
    input  logic [NUM_ENG-1:0] Eng_ready,
    output logic [NUM_ENG-1:0] Eng_start,
    output logic [SW-1:0]      BRAM_select,
    output logic [EW-1:0]      eng_idx
);

    localparam int CW = ADDR_NB + ADDR_GUARD;
    localparam logic [CW-1:0]      LOAD_LIMIT = CW'(LOAD_BASE + LOAD_WORDS - 1);
    localparam logic [NUM_ENG-1:0] ENG0       = NUM_ENG'(1);
    localparam logic [SW-1:0]      SEL_LM     = SW'(BRAM_SEL_LMULM);

    if (NUM_ENG < 1 || NUM_ENG > 8) begin : g_bad_num_eng
        $error("lpd_multi_engine_ctrl: NUM_ENG must be 1..8");
    end
    if (UNLOAD_BASE + NUM_ENG * UNLOAD_WORDS > 2**ADDR_NB ||
        LOAD_BASE + LOAD_WORDS > 2**ADDR_NB) begin : g_bad_map
        $error("lpd_multi_engine_ctrl: BRAM regions exceed address space");
    end

    ctrl_state_t   state;
    logic          first_cyc;
    logic          unl_en_q;
    logic          expire;
    logic [CW-1:0] unl_base;
    logic [CW-1:0] unl_limit;

    assign unl_base  = CW'(UNLOAD_BASE) + CW'(eng_idx) * CW'(UNLOAD_WORDS);
    assign unl_limit = unl_base + CW'(UNLOAD_WORDS - 1);

    // first_cyc masks the LoadUnloadMem ready level still left over from the previous transfer.
    logic load_done, eng_done, unl_done, advance, last_eng;
    assign load_done = (state == ST_LOAD_WAIT)   && !first_cyc && LM_ULM_ready;
    assign eng_done  = (state == ST_ENG_WAIT)    && Eng_ready[eng_idx];
    assign unl_done  = (state == ST_UNLOAD_WAIT) && !first_cyc && LM_ULM_ready;
    assign advance   = (eng_done && !unl_en_q) || unl_done;
    assign last_eng  = (eng_idx == EW'(NUM_ENG - 1));

    lpd_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clr    ((state == ST_IDLE) || load_done || eng_done || unl_done),
        .en     (state != ST_IDLE),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= ST_IDLE;
            ready               <= 1'b1;
            err                 <= 1'b0;
            err_state           <= ERR_NONE;
            LM_ULM_start        <= 1'b0;
            LM_ULM_base_address <= '0;
            LM_ULM_upper_limit  <= '0;
            LM_ULM_load_unload  <= 1'b0;
            Eng_start           <= '0;
            BRAM_select         <= SEL_LM;
            eng_idx             <= '0;
            first_cyc           <= 1'b0;
            unl_en_q            <= 1'b0;
        end else begin
            LM_ULM_start <= 1'b0;
            Eng_start    <= '0;
            first_cyc    <= 1'b0;
            if (abort) begin
                state              <= ST_IDLE;
                ready              <= 1'b1;
                BRAM_select        <= SEL_LM;
                LM_ULM_load_unload <= 1'b0;
            end else if (load_done) begin
                state       <= ST_ENG_WAIT;
                Eng_start   <= ENG0;
                BRAM_select <= SW'(1);
                eng_idx     <= '0;
            end else if (eng_done && unl_en_q) begin
                state               <= ST_UNLOAD_WAIT;
                BRAM_select         <= SEL_LM;
                LM_ULM_start        <= 1'b1;
                LM_ULM_base_address <= ADDR_NB'(unl_base);
                LM_ULM_upper_limit  <= ADDR_NB'(unl_limit);
                LM_ULM_load_unload  <= 1'b1;
                first_cyc           <= 1'b1;
            end else if (advance) begin
                if (last_eng) begin
                    state              <= ST_IDLE;
                    ready              <= 1'b1;
                    BRAM_select        <= SEL_LM;
                    LM_ULM_load_unload <= 1'b0;
                end else begin
                    state       <= ST_ENG_WAIT;
                    eng_idx     <= eng_idx + 1'b1;
                    Eng_start   <= ENG0 << (eng_idx + 1'b1);
                    BRAM_select <= SW'(eng_idx) + SW'(2);
                end
            end else if (expire) begin
                state              <= ST_IDLE;
                ready              <= 1'b1;
                err                <= 1'b1;
                err_state          <= err_code(state);
                BRAM_select        <= SEL_LM;
                LM_ULM_load_unload <= 1'b0;
            end else if (ready && start) begin
                state               <= ST_LOAD_WAIT;
                ready               <= 1'b0;
                err                 <= 1'b0;
                err_state           <= ERR_NONE;
                unl_en_q            <= unload_en;
                LM_ULM_start        <= 1'b1;
                LM_ULM_base_address <= ADDR_NB'(LOAD_BASE);
                LM_ULM_upper_limit  <= ADDR_NB'(LOAD_LIMIT);
                LM_ULM_load_unload  <= 1'b0;
                BRAM_select         <= SEL_LM;
                first_cyc           <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lpd_multi_engine_ctrl.sv
// tb/tb_lpd_multi_engine_ctrl.sv - directed self-checking bench for lpd_multi_engine_ctrl
module tb_lpd_multi_engine_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, unload_en, abort, LM_ULM_ready;
    logic [1:0]  Eng_ready;
    logic        ready, err, LM_ULM_start, LM_ULM_load_unload;
    logic [1:0]  err_state, Eng_start, BRAM_select;
    logic [13:0] LM_ULM_base_address, LM_ULM_upper_limit;
    logic [0:0]  eng_idx;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lpd_multi_engine_ctrl #(
        .ADDR_NB(14), .NUM_ENG(2), .LOAD_BASE(0), .LOAD_WORDS(8192),
        .UNLOAD_BASE(8192), .UNLOAD_WORDS(2048), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .unload_en(unload_en), .abort(abort),
        .ready(ready), .err(err), .err_state(err_state),
        .LM_ULM_ready(LM_ULM_ready), .LM_ULM_start(LM_ULM_start),
        .LM_ULM_base_address(LM_ULM_base_address), .LM_ULM_upper_limit(LM_ULM_upper_limit),
        .LM_ULM_load_unload(LM_ULM_load_unload),
        .Eng_ready(Eng_ready), .Eng_start(Eng_start),
        .BRAM_select(BRAM_select), .eng_idx(eng_idx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".ready"}, ready, 1);
        chk({tag, ".err"}, err, 0);
        chk({tag, ".err_state"}, err_state, 0);
        chk({tag, ".lm_start"}, LM_ULM_start, 0);
        chk({tag, ".base"}, LM_ULM_base_address, 0);
        chk({tag, ".limit"}, LM_ULM_upper_limit, 0);
        chk({tag, ".lu"}, LM_ULM_load_unload, 0);
        chk({tag, ".eng_start"}, Eng_start, 0);
        chk({tag, ".sel"}, BRAM_select, 0);
        chk({tag, ".eng_idx"}, eng_idx, 0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".ready"}, ready, 1);
        chk({tag, ".lm_start"}, LM_ULM_start, 0);
        chk({tag, ".eng_start"}, Eng_start, 0);
        chk({tag, ".sel"}, BRAM_select, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; unload_en = 1'b0; abort = 1'b0;
        LM_ULM_ready = 1'b0; Eng_ready = 2'b00;
        step(2);
        chk_reset_vals("rst");
        reset = 1'b0;
        step(1);

        // 1: full run with unloads
        start = 1'b1; unload_en = 1'b1;
        step(1);
        chk("t1.load_start", LM_ULM_start, 1);
        chk("t1.ready_low", ready, 0);
        chk("t1.load_base", LM_ULM_base_address, 0);
        chk("t1.load_limit", LM_ULM_upper_limit, 8191);
        chk("t1.load_lu", LM_ULM_load_unload, 0);
        chk("t1.load_sel", BRAM_select, 0);
        start = 1'b0;
        step(4);
        LM_ULM_ready = 1'b1;
        step(1);
        chk("t1.eng0_start", Eng_start, 2'b01);
        chk("t1.eng0_sel", BRAM_select, 1);
        chk("t1.eng0_idx", eng_idx, 0);
        LM_ULM_ready = 1'b0;
        step(4);
        chk("t1.eng0_sel_hold", BRAM_select, 1);
        chk("t1.eng0_pulse_once", Eng_start, 0);
        step(5);
        Eng_ready = 2'b01;
        step(1);
        chk("t1.unl0_start", LM_ULM_start, 1);
        chk("t1.unl0_base", LM_ULM_base_address, 8192);
        chk("t1.unl0_limit", LM_ULM_upper_limit, 10239);
        chk("t1.unl0_lu", LM_ULM_load_unload, 1);
        chk("t1.unl0_sel", BRAM_select, 0);
        Eng_ready = 2'b00;
        step(4);
        LM_ULM_ready = 1'b1;
        step(1);
        chk("t1.eng1_start", Eng_start, 2'b10);
        chk("t1.eng1_sel", BRAM_select, 2);
        chk("t1.eng1_idx", eng_idx, 1);
        LM_ULM_ready = 1'b0;
        step(4);
        Eng_ready = 2'b01;
        step(1);
        chk("t1.other_eng_ignored_lm", LM_ULM_start, 0);
        chk("t1.other_eng_ignored_sel", BRAM_select, 2);
        chk("t1.other_eng_ignored_rdy", ready, 0);
        Eng_ready = 2'b00;
        step(4);
        Eng_ready = 2'b10;
        step(1);
        chk("t1.unl1_start", LM_ULM_start, 1);
        chk("t1.unl1_base", LM_ULM_base_address, 10240);
        chk("t1.unl1_limit", LM_ULM_upper_limit, 12287);
        chk("t1.unl1_lu", LM_ULM_load_unload, 1);
        chk("t1.unl1_sel", BRAM_select, 0);
        Eng_ready = 2'b00;
        step(4);
        LM_ULM_ready = 1'b1;
        step(1);
        chk_idle("t1.done");
        chk("t1.done_lu", LM_ULM_load_unload, 0);
        chk("t1.done_err", err, 0);
        LM_ULM_ready = 1'b0;

        // 2: no unloads, start held high throughout
        start = 1'b1; unload_en = 1'b0;
        step(1);
        chk("t2.load_start", LM_ULM_start, 1);
        chk("t2.ready_low", ready, 0);
        step(2);
        LM_ULM_ready = 1'b1;
        step(1);
        chk("t2.eng0_start", Eng_start, 2'b01);
        LM_ULM_ready = 1'b0;
        step(4);
        Eng_ready = 2'b01;
        step(1);
        chk("t2.eng1_start", Eng_start, 2'b10);
        chk("t2.eng1_sel", BRAM_select, 2);
        chk("t2.no_unload", LM_ULM_start, 0);
        Eng_ready = 2'b00;
        step(3);
        Eng_ready = 2'b10;
        step(1);
        chk_idle("t2.done");
        Eng_ready = 2'b00;
        step(1);
        chk("t2.restart_lm", LM_ULM_start, 1);
        chk("t2.restart_ready", ready, 0);
        chk("t2.restart_base", LM_ULM_base_address, 0);
        start = 1'b0;

        // 3: engine 1 never answers
        step(1);
        LM_ULM_ready = 1'b1;
        step(1);
        chk("t3.eng0_start", Eng_start, 2'b01);
        LM_ULM_ready = 1'b0;
        Eng_ready = 2'b01;
        step(1);
        chk("t3.eng1_start", Eng_start, 2'b10);
        Eng_ready = 2'b00;
        step(15);
        chk("t3.pre_err", err, 0);
        chk("t3.pre_ready", ready, 0);
        chk("t3.pre_sel", BRAM_select, 2);
        step(1);
        chk("t3.err", err, 1);
        chk("t3.err_state", err_state, 2);
        chk_idle("t3.to");
        start = 1'b1; unload_en = 1'b1;
        step(1);
        chk("t3.err_cleared", err, 0);
        chk("t3.err_state_cleared", err_state, 0);
        chk("t3.restart_lm", LM_ULM_start, 1);
        start = 1'b0;

        // 4: abort coincides with UNLOAD_WAIT expiry
        step(1);
        LM_ULM_ready = 1'b1;
        step(1);
        chk("t4.eng0_start", Eng_start, 2'b01);
        LM_ULM_ready = 1'b0;
        Eng_ready = 2'b01;
        step(1);
        chk("t4.unl_start", LM_ULM_start, 1);
        chk("t4.unl_lu", LM_ULM_load_unload, 1);
        Eng_ready = 2'b00;
        step(15);
        chk("t4.pre_ready", ready, 0);
        chk("t4.pre_lu", LM_ULM_load_unload, 1);
        abort = 1'b1;
        step(1);
        chk_idle("t4.abort");
        chk("t4.err", err, 0);
        chk("t4.err_state", err_state, 0);
        abort = 1'b0;

        // 5: LM_ULM_ready already high before start
        LM_ULM_ready = 1'b1; unload_en = 1'b0;
        step(1);
        chk("t5.idle_no_start", Eng_start, 0);
        start = 1'b1;
        step(1);
        chk("t5.load_start", LM_ULM_start, 1);
        start = 1'b0;
        step(1);
        chk("t5.ignored_eng", Eng_start, 0);
        chk("t5.ignored_sel", BRAM_select, 0);
        step(1);
        chk("t5.eng0_start", Eng_start, 2'b01);
        chk("t5.eng0_sel", BRAM_select, 1);
        LM_ULM_ready = 1'b0;

        // 6: reset during ENG_WAIT
        reset = 1'b1;
        step(1);
        chk_reset_vals("t6.rst");
        reset = 1'b0;
        Eng_ready = 2'b01;
        step(1);
        chk_idle("t6.after0");
        Eng_ready = 2'b10;
        step(1);
        chk_idle("t6.after1");
        Eng_ready = 2'b00;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
